// File: rtl/demux12_buf.sv
// 1-to-2 demultiplexer with a small FIFO on each output port.
// in_sel steers each accepted word to the tail of queue 0 or queue 1.
module demux12_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  // DEPTH is 2 or 4, so the pointer is 1 or 2 bits wide.
  // The occupancy count needs one extra bit so that it can hold DEPTH.
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] occ_t;

  localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
  localparam occ_t OCC_FULL = occ_t'(DEPTH);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic occ_t occ_next(input occ_t o, input logic push, input logic pop);
    occ_t r;
    r = o;
    if (push && !pop) r = o + occ_t'(1);
    if (pop && !push) r = o - occ_t'(1);
    return r;
  endfunction

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];
  ptr_t             rd_ptr0, wr_ptr0, rd_ptr1, wr_ptr1;
  occ_t             occ0, occ1;
  logic             full0, full1;
  logic             push0, push1, pop0, pop1;

  assign full0 = (occ0 == OCC_FULL);
  assign full1 = (occ1 == OCC_FULL);

  // Readiness looks only at the selected queue's current fill. A full queue
  // stays unready even when its head leaves this cycle, which keeps in_ready
  // independent of out*_ready.
  assign in_ready = in_sel ? !full1 : !full0;

  assign push0 = in_valid && in_ready && !in_sel;
  assign push1 = in_valid && in_ready && in_sel;

  assign out0_valid = (occ0 != '0);
  assign out1_valid = (occ1 != '0);
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  assign out0_data = mem0[rd_ptr0];
  assign out1_data = mem1[rd_ptr1];

  // Storage is not reset; the valid flags qualify the data outputs.
  always_ff @(posedge clk) begin
    if (push0) mem0[wr_ptr0] <= in_data;
    if (push1) mem1[wr_ptr1] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr0 <= '0;
      wr_ptr0 <= '0;
      occ0    <= '0;
      cnt0    <= '0;
    end else begin
      if (push0) wr_ptr0 <= ptr_inc(wr_ptr0);
      if (pop0) begin
        rd_ptr0 <= ptr_inc(rd_ptr0);
        cnt0    <= cnt0 + 8'd1;
      end
      occ0 <= occ_next(occ0, push0, pop0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr1 <= '0;
      wr_ptr1 <= '0;
      occ1    <= '0;
      cnt1    <= '0;
    end else begin
      if (push1) wr_ptr1 <= ptr_inc(wr_ptr1);
      if (pop1) begin
        rd_ptr1 <= ptr_inc(rd_ptr1);
        cnt1    <= cnt1 + 8'd1;
      end
      occ1 <= occ_next(occ1, push1, pop1);
    end
  end

endmodule

// File: tb/tb_demux12_buf.sv
// Self-checking bench for demux12_buf: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_demux12_buf;
  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel, in_valid, in_ready;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0]   cnt0, cnt1;

  demux12_buf #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: one expected queue per port and a delivery count per port.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [7:0]   c0 = 8'd0, c1 = 8'd0;
  int           vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic exp_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out0_valid", 32'(out0_valid), 32'(exp_q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(exp_q1.size() != 0));
    if (exp_q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(exp_q0[0]));
    if (exp_q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(exp_q1[0]));
    chk("cnt0", 32'(cnt0), 32'(c0));
    chk("cnt1", 32'(cnt1), 32'(c1));
  endtask

  // Driver: apply one cycle of inputs on the falling edge, check on the
  // settled values, then advance the model across the rising edge.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1, output logic acc);
    logic er, p0, p1;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    er = s ? (exp_q1.size() < DEPTH) : (exp_q0.size() < DEPTH);
    check_all(er);
    p0  = (exp_q0.size() != 0) && r0;
    p1  = (exp_q1.size() != 0) && r1;
    acc = v && er;
    @(posedge clk);
    if (p0) begin void'(exp_q0.pop_front()); c0 = c0 + 8'd1; end
    if (p1) begin void'(exp_q1.pop_front()); c1 = c1 + 8'd1; end
    if (acc) begin
      if (s) exp_q1.push_back(d);
      else   exp_q0.push_back(d);
    end
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    logic a;
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom), r0, r1, a);
  endtask

  logic         acc, pend, ps;
  logic [W-1:0] pd;
  logic [7:0]   base0, base1;

  initial begin
    // Reset state, observed before the first clock edge.
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Steering: one word to each port, consumers always ready.
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, acc);
    chk("steer_acc0", 32'(acc), 32'd1);
    drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, acc);
    chk("steer_acc1", 32'(acc), 32'd1);
    idle(2, 1'b1, 1'b1);
    chk("steer_cnt0", 32'(cnt0), 32'd1);
    chk("steer_cnt1", 32'(cnt1), 32'd1);

    // Backpressure: fill queue 0, other port still open.
    drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b1, acc);
    drive(1'b1, 1'b0, 8'h02, 1'b0, 1'b1, acc);
    drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, acc);
    chk("full0_blocked", 32'(acc), 32'd0);
    drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b1, acc);
    chk("other_port_open", 32'(acc), 32'd1);
    idle(1, 1'b0, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Full with a concurrent pop: no bypass, accepted the following cycle.
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, acc);
    chk("full_pop_no_bypass", 32'(acc), 32'd0);
    drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b0, acc);
    chk("full_pop_next", 32'(acc), 32'd1);
    idle(3, 1'b1, 1'b1);

    // Streaming: 20 words, alternating ports, transfer every cycle.
    base0 = c0; base1 = c1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'(i % 2), W'($urandom), 1'b1, 1'b1, acc);
      chk("stream_acc", 32'(acc), 32'd1);
    end
    idle(2, 1'b1, 1'b1);
    chk("stream_cnt0", 32'(cnt0), 32'(8'(base0 + 8'd10)));
    chk("stream_cnt1", 32'(cnt1), 32'(8'(base1 + 8'd10)));

    // Random traffic; a blocked word is held until it is accepted.
    pend = 1'b0; ps = 1'b0; pd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; pd = W'($urandom); ps = 1'($urandom_range(0, 1));
      end
      if (!pend) ps = 1'($urandom_range(0, 1));
      drive(pend, ps, pd, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6), acc);
      if (acc) pend = 1'b0;
    end
    idle(4, 1'b1, 1'b1);

    // Counter wrap: 256 deliveries on port 1.
    base0 = c0; base1 = c1;
    for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, W'($urandom), 1'b1, 1'b1, acc);
    idle(2, 1'b1, 1'b1);
    chk("wrap_cnt1", 32'(cnt1), 32'(base1));
    chk("wrap_cnt0", 32'(cnt0), 32'(base0));

    // Asynchronous reset mid-cycle with both queues holding data.
    drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b1, 8'hC4, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out0_valid", 32'(out0_valid), 32'd0);
    chk("arst_out1_valid", 32'(out1_valid), 32'd0);
    chk("arst_cnt0", 32'(cnt0), 32'd0);
    chk("arst_cnt1", 32'(cnt1), 32'd0);
    in_sel = 1'b0; #1;
    chk("arst_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1; #1;
    chk("arst_ready_sel1", 32'(in_ready), 32'd1);
    exp_q0.delete(); exp_q1.delete(); c0 = 8'd0; c1 = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // First word after reset appears one edge after acceptance.
    drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, acc);
    chk("post_rst_acc", 32'(acc), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("post_rst_out0", 32'(out0_data), 32'h5A);
    idle(2, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
